// File: rtl/instr_mem_loader_pkg.sv
// Shared definitions for the boot-time instruction memory loader.
package instr_mem_loader_pkg;

  typedef enum logic [2:0] {
    LD_IDLE  = 3'd0,
    LD_HDR   = 3'd1,
    LD_DATA  = 3'd2,
    LD_WRITE = 3'd3,
    LD_DONE  = 3'd4,
    LD_ERR   = 3'd5
  } ld_state_e;

  // Number of stream bytes that make up one word of the given width.
  function automatic int bytes_of(input int data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/instr_mem_loader_byte_assembler.sv
// MSB-first byte-to-word shift register with a byte counter; shared by the
// header and data phases of the loader.
module byte_assembler
  import instr_mem_loader_pkg::*;
#(
  parameter int DATA = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            shift_i,
  input  logic            clear_i,
  input  logic [7:0]      byte_i,
  output logic [DATA-1:0] word_o,
  output logic            full_o,
  output logic            last_o
);

  localparam int BYTES = bytes_of(DATA);
  localparam int CW    = $clog2(BYTES + 1);

  logic [CW-1:0]   cnt_q, cnt_d, cnt_base;
  logic [DATA-1:0] word_q, word_d, word_next;

  // clear and shift together restart the count with the incoming byte,
  // so a new word can begin in the same cycle the old one is discarded
  always_comb begin
    cnt_base  = clear_i ? {CW{1'b0}} : cnt_q;
    word_next = (word_q << 8) | DATA'(byte_i);
    if (shift_i) begin
      cnt_d  = cnt_base + CW'(1);
      word_d = word_next;
    end else begin
      cnt_d  = cnt_base;
      word_d = word_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= {CW{1'b0}};
      word_q <= {DATA{1'b0}};
    end else begin
      cnt_q  <= cnt_d;
      word_q <= word_d;
    end
  end

  // word_o already includes byte_i, so the caller can act on the final byte
  // in the cycle it is accepted
  assign word_o = word_next;
  assign full_o = (cnt_q == CW'(BYTES));
  assign last_o = (cnt_base == CW'(BYTES - 1));

endmodule

// File: rtl/instr_mem_loader.sv
// Boot loader: receives a length header plus machine-code words and writes
// them into instr_mem, holding the core in reset until the program is resident.
module instr_mem_loader
  import instr_mem_loader_pkg::*;
#(
  parameter int DATA      = 32,
  parameter int ADDR      = 32,
  parameter int MEM_DEPTH = 256
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [7:0]      rx_data,
  input  logic            rx_valid,
  output logic            rx_ready,
  output logic            mem_we,
  output logic [ADDR-1:0] mem_addr,
  output logic [DATA-1:0] mem_wd,
  output logic            cpu_hold,
  output logic            done,
  output logic            err,
  output logic [ADDR-1:0] words_loaded
);

  ld_state_e       state_q, state_d;
  logic [ADDR-1:0] idx_q, idx_d, len_q, len_d, words_q, words_d;
  logic [ADDR-1:0] mem_addr_q, mem_addr_d;
  logic [DATA-1:0] mem_wd_q, mem_wd_d, asm_word;
  logic            rx_ready_q, rx_ready_d, mem_we_q, mem_we_d;
  logic            cpu_hold_q, cpu_hold_d, done_q, done_d, err_q, err_d;
  logic            accept, asm_full, asm_last, asm_clear, word_end, restart;

  assign accept    = rx_valid & rx_ready_q;
  assign word_end  = accept & asm_last;
  assign asm_clear = asm_full | ~((state_q == LD_HDR) | (state_q == LD_DATA));
  assign restart   = start & ((state_q == LD_IDLE) | (state_q == LD_DONE) | (state_q == LD_ERR));

  byte_assembler #(.DATA(DATA)) u_asm (
    .clk     (clk),
    .rst     (rst),
    .shift_i (accept),
    .clear_i (asm_clear),
    .byte_i  (rx_data),
    .word_o  (asm_word),
    .full_o  (asm_full),
    .last_o  (asm_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= LD_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      LD_IDLE:  if (start) state_d = LD_HDR; else state_d = LD_IDLE;
      LD_HDR: begin
        if (!word_end)                           state_d = LD_HDR;
        else if (asm_word == {DATA{1'b0}})       state_d = LD_DONE;
        else if (asm_word > DATA'(MEM_DEPTH))    state_d = LD_ERR;
        else                                     state_d = LD_DATA;
      end
      LD_DATA:  if (word_end) state_d = LD_WRITE; else state_d = LD_DATA;
      LD_WRITE: if (idx_q + ADDR'(1) == len_q) state_d = LD_DONE; else state_d = LD_DATA;
      LD_DONE:  if (start) state_d = LD_HDR; else state_d = LD_DONE;
      LD_ERR:   if (start) state_d = LD_HDR; else state_d = LD_ERR;
      default:  state_d = LD_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so every port comes from a flop
  always_comb begin
    rx_ready_d = (state_d == LD_HDR) | (state_d == LD_DATA);
    mem_we_d   = (state_d == LD_WRITE);
    mem_addr_d = mem_we_d ? idx_q : mem_addr_q;
    mem_wd_d   = mem_we_d ? asm_word : mem_wd_q;
    cpu_hold_d = (state_d != LD_DONE);
    done_d     = (state_d == LD_DONE);
    err_d      = (state_d == LD_ERR);
    len_d      = ((state_q == LD_HDR) && word_end) ? ADDR'(asm_word) : len_q;
    idx_d      = idx_q;
    words_d    = words_q;
    if (restart) begin
      idx_d   = {ADDR{1'b0}};
      words_d = {ADDR{1'b0}};
    end else if (state_q == LD_WRITE) begin
      // idx stops at len-1; words_loaded counts the final write too
      idx_d   = (idx_q + ADDR'(1) == len_q) ? idx_q : idx_q + ADDR'(1);
      words_d = words_q + ADDR'(1);
    end else begin
      idx_d   = idx_q;
      words_d = words_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_ready_q <= 1'b0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= {ADDR{1'b0}};
      mem_wd_q   <= {DATA{1'b0}};
      cpu_hold_q <= 1'b1;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      len_q      <= {ADDR{1'b0}};
      idx_q      <= {ADDR{1'b0}};
      words_q    <= {ADDR{1'b0}};
    end else begin
      rx_ready_q <= rx_ready_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_wd_q   <= mem_wd_d;
      cpu_hold_q <= cpu_hold_d;
      done_q     <= done_d;
      err_q      <= err_d;
      len_q      <= len_d;
      idx_q      <= idx_d;
      words_q    <= words_d;
    end
  end

  assign rx_ready     = rx_ready_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wd       = mem_wd_q;
  assign cpu_hold     = cpu_hold_q;
  assign done         = done_q;
  assign err          = err_q;
  assign words_loaded = words_q;

endmodule
